// File: rtl/tlp_pkg.sv
// Shared definitions for the receive-completion reorder engine.
package tlp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_RELEASE = 2'd2
  } cpl_state_e;

  // Descriptor bits sitting above the TAG_W-wide tag field
  localparam int unsigned DESC_VALID_OFS = 0;
  localparam int unsigned DESC_LAST_OFS  = 1;

  // Buffer-data bits sitting above the DATA_W-wide payload field
  localparam int unsigned BUF_ERR_OFS = 0;
  localparam int unsigned BUF_EOP_OFS = 1;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/tlp_rxcpl_reorder_if.sv
// Avalon slave read-data stream (valid/ready) from the reorder engine.
interface tlp_rxcpl_reorder_if #(
  parameter int unsigned DATA_W = 128
);
  logic [DATA_W-1:0] TxsReadData;
  logic              TxsReadDataValid;
  logic              TxsReadDataReady;
  logic              TxsReadErr;

  modport master (
    output TxsReadData,
    output TxsReadDataValid,
    output TxsReadErr,
    input  TxsReadDataReady
  );

  modport slave (
    input  TxsReadData,
    input  TxsReadDataValid,
    input  TxsReadErr,
    output TxsReadDataReady
  );
endinterface

// File: rtl/tlp_cpl_skid.sv
// Two-entry valid/ready skid buffer; the output beat always comes from a register.
module tlp_cpl_skid
  import tlp_pkg::*;
#(
  parameter int unsigned W = 129
) (
  input  logic                  AvlClk_i,
  input  logic                  Rst_i,
  input  logic                  in_vld,
  input  logic [W-1:0]          in_data,
  output logic                  out_vld,
  output logic [W-1:0]          out_data,
  input  logic                  out_rdy,
  output logic [SKID_CNT_W-1:0] cnt
);

  logic         skd_vld_q;
  logic [W-1:0] skd_data_q;
  logic         pop;

  assign pop = out_vld & out_rdy;
  assign cnt = SKID_CNT_W'(out_vld) + SKID_CNT_W'(skd_vld_q);

  // Output register refills from the skid slot first so order is preserved
  always_ff @(posedge AvlClk_i) begin
    if (Rst_i) begin
      out_vld    <= 1'b0;
      out_data   <= '0;
      skd_vld_q  <= 1'b0;
      skd_data_q <= '0;
    end else if (pop) begin
      if (skd_vld_q) begin
        out_data  <= skd_data_q;
        skd_vld_q <= in_vld;
        if (in_vld) skd_data_q <= in_data;
      end else begin
        out_vld <= in_vld;
        if (in_vld) out_data <= in_data;
      end
    end else if (in_vld) begin
      if (!out_vld) begin
        out_vld  <= 1'b1;
        out_data <= in_data;
      end else begin
        skd_vld_q  <= 1'b1;
        skd_data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/tlp_rxcpl_reorder.sv
// Receive-completion reorder engine: drains fully landed tags in tag order.
module tlp_rxcpl_reorder
  import tlp_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned SLOT_AW = 5,
  parameter int unsigned DATA_W  = 128
) (
  input  logic                     AvlClk_i,
  input  logic                     Rst_i,
  input  logic                     RxCplReq_i,
  input  logic [TAG_W+1:0]         RxCplDesc_i,
  output logic [TAG_W+SLOT_AW-1:0] RxCplRdAddr_o,
  input  logic [DATA_W+1:0]        RxCplBufData_i,
  output logic                     RxCplBuffFree_o,
  output logic [TAG_W-1:0]         RxCplFreeTag_o,
  tlp_rxcpl_reorder_if.master      txs,
  output logic [(1<<TAG_W)-1:0]    TagPending_o,
  output logic                     Overrun_o
);

  localparam int unsigned NTAG = 1 << TAG_W;
  localparam logic [SLOT_AW-1:0] BEAT_MAX = '1;

  cpl_state_e          state_q;
  logic [TAG_W-1:0]    hol_q;
  logic [SLOT_AW-1:0]  beat_q;
  logic [NTAG-1:0]     pend_q, pend_nxt;
  logic [NTAG-1:0]     partial_q, partial_nxt;
  logic                rd_vld_q, rd_last_q;
  logic                free_q;
  logic [TAG_W-1:0]    free_tag_q;
  logic                overrun_q;

  logic [TAG_W-1:0]    desc_tag;
  logic                desc_vld, desc_last;
  logic                buf_eop, buf_err;
  logic                beat_end_c, ovf_c, push_c, pop_c, issue_c, dup_c;
  logic [2:0]          occ_c;
  logic                skid_vld;
  logic [DATA_W:0]     skid_out;
  logic [SKID_CNT_W-1:0] skid_cnt;

  assign desc_tag  = RxCplDesc_i[TAG_W-1:0];
  assign desc_vld  = RxCplDesc_i[TAG_W+DESC_VALID_OFS];
  assign desc_last = RxCplDesc_i[TAG_W+DESC_LAST_OFS];
  assign buf_eop   = RxCplBufData_i[DATA_W+BUF_EOP_OFS];
  assign buf_err   = RxCplBufData_i[DATA_W+BUF_ERR_OFS];

  // A returning beat ends the region on eop or on the last slot of the region
  assign beat_end_c = rd_vld_q & (buf_eop | rd_last_q);
  assign ovf_c      = rd_vld_q & rd_last_q & ~buf_eop;
  assign push_c     = rd_vld_q & (state_q == ST_STREAM);
  assign pop_c      = skid_vld & txs.TxsReadDataReady;
  assign occ_c      = 3'(skid_cnt) + 3'(rd_vld_q) - 3'(pop_c);

  // Read issue: only when the skid is guaranteed room for the returning beat
  always_comb begin
    issue_c = 1'b0;
    if (occ_c < 3'(SKID_DEPTH)) begin
      case (state_q)
        ST_IDLE:   issue_c = pend_q[hol_q];
        ST_STREAM: issue_c = ~beat_end_c;
        default:   issue_c = 1'b0;
      endcase
    end
  end

  // Tag status update; a set in the release cycle wins over the clear
  always_comb begin
    pend_nxt    = pend_q;
    partial_nxt = partial_q;
    dup_c       = 1'b0;
    if (state_q == ST_RELEASE) pend_nxt[hol_q] = 1'b0;
    if (RxCplReq_i) begin
      if (desc_last) begin
        if (pend_q[desc_tag] && !((state_q == ST_RELEASE) && (desc_tag == hol_q))) begin
          dup_c = 1'b1;
        end else begin
          pend_nxt[desc_tag]    = 1'b1;
          partial_nxt[desc_tag] = 1'b0;
        end
      end else begin
        partial_nxt[desc_tag] = desc_vld;
      end
    end
  end

  // Drain FSM, read pipeline tracking and registered status outputs
  always_ff @(posedge AvlClk_i) begin
    if (Rst_i) begin
      state_q    <= ST_IDLE;
      hol_q      <= '0;
      beat_q     <= '0;
      pend_q     <= '0;
      partial_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      free_q     <= 1'b0;
      free_tag_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      pend_q    <= pend_nxt;
      partial_q <= partial_nxt;
      rd_vld_q  <= issue_c;
      rd_last_q <= issue_c & (beat_q == BEAT_MAX);
      free_q    <= 1'b0;
      if (dup_c || ovf_c) overrun_q <= 1'b1;
      if (issue_c) beat_q <= beat_q + SLOT_AW'(1);
      case (state_q)
        ST_IDLE: begin
          if (issue_c) state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          if (beat_end_c) state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          free_q     <= 1'b1;
          free_tag_q <= hol_q;
          hol_q      <= hol_q + TAG_W'(1);
          beat_q     <= '0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tlp_cpl_skid #(
    .W(DATA_W + 1)
  ) u_skid (
    .AvlClk_i (AvlClk_i),
    .Rst_i    (Rst_i),
    .in_vld   (push_c),
    .in_data  ({buf_err | ovf_c, RxCplBufData_i[DATA_W-1:0]}),
    .out_vld  (skid_vld),
    .out_data (skid_out),
    .out_rdy  (txs.TxsReadDataReady),
    .cnt      (skid_cnt)
  );

  assign txs.TxsReadData      = skid_out[DATA_W-1:0];
  assign txs.TxsReadErr       = skid_out[DATA_W];
  assign txs.TxsReadDataValid = skid_vld;

  assign RxCplRdAddr_o   = {hol_q, beat_q};
  assign RxCplBuffFree_o = free_q;
  assign RxCplFreeTag_o  = free_tag_q;
  assign TagPending_o    = pend_q;
  assign Overrun_o       = overrun_q;

endmodule

// File: tb/tb_tlp_rxcpl_reorder.sv
// Self-checking bench for tlp_rxcpl_reorder with a scoreboard on the read-data stream.
module tb_tlp_rxcpl_reorder;

  localparam int unsigned TAG_W   = 4;
  localparam int unsigned SLOT_AW = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NTAG    = 1 << TAG_W;
  localparam int unsigned NBEAT   = 1 << SLOT_AW;

  logic                     clk;
  logic                     Rst_i;
  logic                     req;
  logic [TAG_W+1:0]         desc;
  logic [TAG_W+SLOT_AW-1:0] rd_addr;
  logic [DATA_W+1:0]        buf_data;
  logic                     free;
  logic [TAG_W-1:0]         free_tag;
  logic [NTAG-1:0]          pending;
  logic                     overrun;

  logic [DATA_W+1:0] mem [NTAG*NBEAT];

  logic [DATA_W:0]   exp_q[$];
  logic [TAG_W-1:0]  free_exp_q[$];

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  tlp_rxcpl_reorder_if #(.DATA_W(DATA_W)) txs_if ();

  tlp_rxcpl_reorder #(
    .TAG_W(TAG_W), .SLOT_AW(SLOT_AW), .DATA_W(DATA_W)
  ) dut (
    .AvlClk_i        (clk),
    .Rst_i           (Rst_i),
    .RxCplReq_i      (req),
    .RxCplDesc_i     (desc),
    .RxCplRdAddr_o   (rd_addr),
    .RxCplBufData_i  (buf_data),
    .RxCplBuffFree_o (free),
    .RxCplFreeTag_o  (free_tag),
    .txs             (txs_if),
    .TagPending_o    (pending),
    .Overrun_o       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completion buffer model: one-cycle registered read
  always @(posedge clk) buf_data <= mem[rd_addr];

  function automatic logic [DATA_W-1:0] pay(input int tag, input int b, input int salt);
    return DATA_W'(salt * 65536 + tag * 256 + b) ^ 32'hC3A5_0000;
  endfunction

  task automatic load_region(input int tag, input int nb, input bit with_eop, input int err_beat, input int salt);
    for (int b = 0; b < int'(NBEAT); b++) begin
      if (b < nb)
        mem[tag*NBEAT + b] = {with_eop && (b == nb - 1), b == err_beat, pay(tag, b, salt)};
      else
        mem[tag*NBEAT + b] = {2'b00, DATA_W'(32'hDEAD_0000 + b)};
    end
  endtask

  task automatic expect_region(input int tag, input int nb, input bit with_eop, input int err_beat, input int salt);
    for (int b = 0; b < nb; b++)
      exp_q.push_back({(b == err_beat) || (!with_eop && b == int'(NBEAT) - 1), pay(tag, b, salt)});
  endtask

  task automatic strobe(input int tag, input bit last);
    @(posedge clk); #1;
    req  = 1'b1;
    desc = {last, 1'b1, TAG_W'(tag)};
    @(posedge clk); #1;
    req  = 1'b0;
    desc = '0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || free_exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || free_exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: beats left %0d frees left %0d, required 0/0", name, exp_q.size(), free_exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Output monitor: scoreboard pops, hold-while-stalled and release-pulse checks
  initial begin
    logic [DATA_W:0] got, prev, e;
    logic            prev_stall;
    logic [TAG_W-1:0] ft;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      got = {txs_if.TxsReadErr, txs_if.TxsReadData};
      if (Rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          stalls++;
          if (!txs_if.TxsReadDataValid || got !== prev) begin
            errors++;
            $display("FAIL hold: got v=%0b %0h required v=1 %0h", txs_if.TxsReadDataValid, got, prev);
          end
        end
        if (txs_if.TxsReadDataValid && txs_if.TxsReadDataReady) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: got unexpected beat %0h required none", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL beat: got %0h required %0h", got, e);
            end
          end
        end
        if (free) begin
          checks++;
          if (free_exp_q.size() == 0) begin
            errors++;
            $display("FAIL free: got unexpected release tag %0d required none", free_tag);
          end else begin
            ft = free_exp_q.pop_front();
            if (free_tag !== ft) begin
              errors++;
              $display("FAIL free_tag: got %0d required %0d", free_tag, ft);
            end
          end
        end
        prev_stall = txs_if.TxsReadDataValid && !txs_if.TxsReadDataReady;
        prev = got;
      end
    end
  end

  task automatic test_reset;
    Rst_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (txs_if.TxsReadDataValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b required 0", txs_if.TxsReadDataValid); end
    if (free !== 1'b0) begin errors++; $display("FAIL rst_free: got %0b required 0", free); end
    if (pending !== '0) begin errors++; $display("FAIL rst_pend: got %0h required 0", pending); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %0b required 0", overrun); end
    if (rd_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0h required 0", rd_addr); end
    @(posedge clk); #1;
    Rst_i = 1'b0;
  endtask

  task automatic test_single;
    load_region(0, 4, 1'b1, -1, 1);
    expect_region(0, 4, 1'b1, -1, 1);
    free_exp_q.push_back(TAG_W'(0));
    strobe(0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks += 2;
        if (pending !== NTAG'(1)) begin errors++; $display("FAIL single_pend: got %0h required 1", pending); end
        if (rd_addr !== '0) begin errors++; $display("FAIL single_addr: got %0h required 0", rd_addr); end
      end
      checks += 2;
      if (txs_if.TxsReadDataValid !== (c >= 3 && c <= 6)) begin
        errors++;
        $display("FAIL single_valid c%0d: got %0b required %0b", c, txs_if.TxsReadDataValid, (c >= 3 && c <= 6));
      end
      if (free !== (c == 7)) begin
        errors++;
        $display("FAIL single_free c%0d: got %0b required %0b", c, free, (c == 7));
      end
    end
    wait_idle(50, "single");
    checks += 2;
    if (rd_addr[TAG_W+SLOT_AW-1:SLOT_AW] !== TAG_W'(1)) begin errors++; $display("FAIL single_hol: got %0d required 1", rd_addr[TAG_W+SLOT_AW-1:SLOT_AW]); end
    if (pending !== '0) begin errors++; $display("FAIL single_pend_clr: got %0h required 0", pending); end
  endtask

  task automatic test_out_of_order;
    load_region(1, 2, 1'b1, -1, 2);
    load_region(2, 3, 1'b1, 1, 2);
    load_region(3, 1, 1'b1, -1, 2);
    expect_region(1, 2, 1'b1, -1, 2);
    expect_region(2, 3, 1'b1, 1, 2);
    expect_region(3, 1, 1'b1, -1, 2);
    free_exp_q.push_back(TAG_W'(1));
    free_exp_q.push_back(TAG_W'(2));
    free_exp_q.push_back(TAG_W'(3));
    strobe(2, 1'b0);
    @(negedge clk);
    checks++;
    if (pending !== '0) begin errors++; $display("FAIL ooo_partial: got %0h required 0", pending); end
    strobe(3, 1'b1);
    strobe(2, 1'b1);
    @(negedge clk);
    checks += 2;
    if (pending !== NTAG'(16'h000C)) begin errors++; $display("FAIL ooo_pend: got %0h required c", pending); end
    if (txs_if.TxsReadDataValid !== 1'b0) begin errors++; $display("FAIL ooo_blocked: got %0b required 0", txs_if.TxsReadDataValid); end
    strobe(1, 1'b1);
    wait_idle(100, "ooo");
    checks += 2;
    if (pending !== '0) begin errors++; $display("FAIL ooo_pend_clr: got %0h required 0", pending); end
    if (rd_addr[TAG_W+SLOT_AW-1:SLOT_AW] !== TAG_W'(4)) begin errors++; $display("FAIL ooo_hol: got %0d required 4", rd_addr[TAG_W+SLOT_AW-1:SLOT_AW]); end
  endtask

  task automatic test_backpressure;
    int n = 0;
    int s0;
    s0 = stalls;
    load_region(4, 8, 1'b1, 6, 3);
    expect_region(4, 8, 1'b1, 6, 3);
    free_exp_q.push_back(TAG_W'(4));
    txs_if.TxsReadDataReady = 1'b1;
    strobe(4, 1'b1);
    while ((exp_q.size() != 0 || free_exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      txs_if.TxsReadDataReady = ~txs_if.TxsReadDataReady;
      n++;
    end
    txs_if.TxsReadDataReady = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (exp_q.size() != 0 || free_exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: beats left %0d required 0", exp_q.size()); end
    if (stalls == s0) begin errors++; $display("FAIL bp_stall: got 0 stalled cycles required >0"); end
    if (rd_addr[TAG_W+SLOT_AW-1:SLOT_AW] !== TAG_W'(5)) begin errors++; $display("FAIL bp_hol: got %0d required 5", rd_addr[TAG_W+SLOT_AW-1:SLOT_AW]); end
  endtask

  task automatic test_duplicate;
    load_region(5, 8, 1'b1, -1, 4);
    expect_region(5, 8, 1'b1, -1, 4);
    free_exp_q.push_back(TAG_W'(5));
    @(posedge clk); #1;
    txs_if.TxsReadDataReady = 1'b0;
    strobe(5, 1'b1);
    repeat (4) @(negedge clk);
    checks += 3;
    if (overrun !== 1'b0) begin errors++; $display("FAIL dup_pre_overrun: got %0b required 0", overrun); end
    if (pending !== NTAG'(16'h0020)) begin errors++; $display("FAIL dup_pre_pend: got %0h required 20", pending); end
    if (txs_if.TxsReadDataValid !== 1'b1) begin errors++; $display("FAIL dup_stalled_valid: got %0b required 1", txs_if.TxsReadDataValid); end
    strobe(5, 1'b1);
    @(negedge clk);
    checks += 2;
    if (overrun !== 1'b1) begin errors++; $display("FAIL dup_overrun: got %0b required 1", overrun); end
    if (pending !== NTAG'(16'h0020)) begin errors++; $display("FAIL dup_pend: got %0h required 20", pending); end
    @(posedge clk); #1;
    txs_if.TxsReadDataReady = 1'b1;
    wait_idle(100, "dup");
    checks += 2;
    if (pending !== '0) begin errors++; $display("FAIL dup_pend_clr: got %0h required 0", pending); end
    if (overrun !== 1'b1) begin errors++; $display("FAIL dup_sticky: got %0b required 1", overrun); end
  endtask

  task automatic test_reset_mid_drain;
    load_region(6, 8, 1'b1, -1, 5);
    expect_region(6, 8, 1'b1, -1, 5);
    free_exp_q.push_back(TAG_W'(6));
    @(posedge clk); #1;
    txs_if.TxsReadDataReady = 1'b0;
    strobe(6, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (txs_if.TxsReadDataValid !== 1'b1) begin errors++; $display("FAIL rmid_valid_pre: got %0b required 1", txs_if.TxsReadDataValid); end
    @(posedge clk); #1;
    Rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (txs_if.TxsReadDataValid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b required 0", txs_if.TxsReadDataValid); end
    if (pending !== '0) begin errors++; $display("FAIL rmid_pend: got %0h required 0", pending); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %0b required 0", overrun); end
    if (free !== 1'b0) begin errors++; $display("FAIL rmid_free: got %0b required 0", free); end
    if (rd_addr !== '0) begin errors++; $display("FAIL rmid_addr: got %0h required 0", rd_addr); end
    exp_q.delete();
    free_exp_q.delete();
    @(posedge clk); #1;
    Rst_i = 1'b0;
    txs_if.TxsReadDataReady = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (txs_if.TxsReadDataValid !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %0b required 0", txs_if.TxsReadDataValid); end
  endtask

  task automatic test_release_collide;
    load_region(0, 1, 1'b1, -1, 6);
    expect_region(0, 1, 1'b1, -1, 6);
    free_exp_q.push_back(TAG_W'(0));
    strobe(0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req  = 1'b1;
    desc = {1'b1, 1'b1, TAG_W'(0)};
    @(posedge clk); #1;
    req  = 1'b0;
    desc = '0;
    @(negedge clk);
    checks += 3;
    if (free !== 1'b1) begin errors++; $display("FAIL coll_free: got %0b required 1", free); end
    if (pending !== NTAG'(1)) begin errors++; $display("FAIL coll_pend: got %0h required 1", pending); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun: got %0b required 0", overrun); end
    wait_idle(50, "coll");
    checks += 2;
    if (pending !== NTAG'(1)) begin errors++; $display("FAIL coll_pend_kept: got %0h required 1", pending); end
    if (rd_addr[TAG_W+SLOT_AW-1:SLOT_AW] !== TAG_W'(1)) begin errors++; $display("FAIL coll_hol: got %0d required 1", rd_addr[TAG_W+SLOT_AW-1:SLOT_AW]); end
  endtask

  task automatic test_wrap;
    for (int t = 1; t < int'(NTAG); t++) begin
      load_region(t, 1 + (t % 3), 1'b1, -1, 7);
      expect_region(t, 1 + (t % 3), 1'b1, -1, 7);
      free_exp_q.push_back(TAG_W'(t));
    end
    expect_region(0, 1, 1'b1, -1, 6);
    free_exp_q.push_back(TAG_W'(0));
    for (int t = 1; t < int'(NTAG); t++) strobe(t, 1'b1);
    wait_idle(400, "wrap");
    checks += 2;
    if (pending !== '0) begin errors++; $display("FAIL wrap_pend: got %0h required 0", pending); end
    if (rd_addr[TAG_W+SLOT_AW-1:SLOT_AW] !== TAG_W'(1)) begin errors++; $display("FAIL wrap_hol: got %0d required 1", rd_addr[TAG_W+SLOT_AW-1:SLOT_AW]); end
  endtask

  task automatic test_overflow;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %0b required 0", overrun); end
    load_region(1, int'(NBEAT), 1'b0, 5, 8);
    expect_region(1, int'(NBEAT), 1'b0, 5, 8);
    free_exp_q.push_back(TAG_W'(1));
    strobe(1, 1'b1);
    wait_idle(200, "ovf");
    checks += 3;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovf_overrun: got %0b required 1", overrun); end
    if (pending !== '0) begin errors++; $display("FAIL ovf_pend: got %0h required 0", pending); end
    if (rd_addr[TAG_W+SLOT_AW-1:SLOT_AW] !== TAG_W'(2)) begin errors++; $display("FAIL ovf_hol: got %0d required 2", rd_addr[TAG_W+SLOT_AW-1:SLOT_AW]); end
  endtask

  initial begin
    Rst_i = 1'b1;
    req   = 1'b0;
    desc  = '0;
    txs_if.TxsReadDataReady = 1'b1;
    for (int i = 0; i < int'(NTAG * NBEAT); i++) mem[i] = '0;
    test_reset;
    test_single;
    test_out_of_order;
    test_backpressure;
    test_duplicate;
    test_reset_mid_drain;
    test_release_collide;
    test_wrap;
    test_overflow;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule

// File: doc/tlp_rxcpl_reorder.md
# tlp_rxcpl_reorder

Parametrised receive-completion reorder and drain engine for the PCIe-to-Avalon bridge. It tracks which outstanding read tags have fully landed in the completion buffer and drains them strictly in tag order, head-of-line first. Drained beats go to the Avalon slave read-data port through a two-entry skid buffer, so downstream backpressure is supported. It releases each tag's buffer region back to TX control. It generalises the fixed 16-tag, 128-bit, no-backpressure controller to configurable tag count, region depth and data width, and adds error propagation and overrun detection.

## Interface
- TAG_W, 4: tag width; 2^TAG_W tags, each with one buffer region.
- SLOT_AW, 5: beats per region = 2^SLOT_AW.
- DATA_W, 128: read-data width.

Ports:
- AvlClk_i  in  1  sole clock.
- Rst_i  in  1  synchronous, active-high reset.
- RxCplReq_i  in  1  one-cycle descriptor strobe; one strobe per completion TLP.
- RxCplDesc_i  in  TAG_W+2  descriptor fields:
  - [TAG_W-1:0] tag.
  - [TAG_W] valid.
  - [TAG_W+1] last completion of the request.
- RxCplRdAddr_o  out  TAG_W+SLOT_AW  completion-buffer read address = {hol_tag, beat_idx}; buffer read latency is fixed at 1 cycle.
- RxCplBufData_i  in  DATA_W+2  buffer read data:
  - [DATA_W+1] eop.
  - [DATA_W] err (poisoned or UR).
  - [DATA_W-1:0] payload.
- RxCplBuffFree_o  out  1  one-cycle pulse: region released.
- RxCplFreeTag_o  out  TAG_W  tag being released; valid with RxCplBuffFree_o.
- TxsReadData_o  out  DATA_W  payload.
- TxsReadDataValid_o  out  1  beat valid.
- TxsReadDataReady_i  in  1  downstream accepts the beat.
- TxsReadErr_o  out  1  error flag qualified by valid.
- TagPending_o  out  2^TAG_W  per-tag "complete and awaiting drain" flags.
- Overrun_o  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- Tag status: a strobe with the last bit set sets pend[tag]. A strobe with last clear only records valid, for debug. A strobe whose tag is already pending is ignored and sets Overrun_o.
- FSM states:
  - IDLE: when pend[hol] is set, issue a read at beat 0 and go to STREAM.
  - STREAM: issue the next address only while skid occupancy + reads in flight − pop < 2. On the returning beat with eop set, stop issuing, discard any read already in flight, and go to RELEASE.
  - RELEASE: for one cycle, pulse RxCplBuffFree_o with RxCplFreeTag_o = hol, clear pend[hol], advance hol modulo 2^TAG_W, reset beat_idx to 0, then go to IDLE.
- Region overflow: if beat_idx reaches 2^SLOT_AW−1 without eop, that beat is treated as eop. It is forwarded with TxsReadErr_o = 1 and Overrun_o is set.
- Each beat's err bit passes through to TxsReadErr_o alongside that beat.
- Simultaneous events: in the RELEASE cycle, a strobe for the tag being released sets pend, because set has priority over clear. That case does not flag an overrun.
- Output handshake: valid/ready. TxsReadData_o and TxsReadErr_o are held stable while valid is high and ready is low. A beat is never dropped or duplicated.
- Reset values:
  - All outputs 0; TxsReadDataValid_o = 0.
  - pend = 0, hol = 0, Overrun_o = 0, FSM in IDLE.
  - Skid buffer emptied.
- Reset mid-drain abandons the transfer with no release pulse.

## Timing
- Descriptor with last at cycle 0 gives:
  - pend set at cycle 1.
  - first address issued at cycle 1.
  - data returns at cycle 2.
  - TxsReadDataValid_o high at cycle 3 (registered skid output).
- With ready held high, throughput is 1 beat per cycle.
- The release pulse comes 2 cycles after the eop beat returns. The next tag's first address follows no earlier than 1 cycle after RELEASE.
- Ready low stalls address issue within 1 cycle. At most 2 beats are buffered.

## Structure
- Shared package tlp_pkg holds:
  - the FSM state encoding.
  - descriptor and buffer-data field offsets.
  - the skid depth constant (2).
- Sub-module tlp_cpl_skid: 2-entry valid/ready buffer with registered output, parametrised on width DATA_W+1.

## Test plan
- Single tag: tag 0 with last, 4 beats with eop on beat 3 → 4 valid beats starting at cycle 3, then RxCplBuffFree_o with tag 0, and hol = 1.
- Out-of-order arrival: tags 2, 1, 0 complete in that order → output order is tag 0, then 1, then 2, with three release pulses for tags 0, 1, 2.
- Backpressure: ready toggled 1010… during an 8-beat drain → exactly 8 beats accepted in order, and data is held stable while stalled.
- Wrap and overflow:
  - TAG_W = 2: tags 0–3, then 0 again → hol wraps from 3 to 0.
  - A region with no eop → 32 beats, last beat has err set, and Overrun_o = 1.
- Duplicate descriptor and reset:
  - Pending tag 5 strobed again → ignored and Overrun_o set.
  - Rst_i asserted mid-drain → valid = 0 and TagPending_o = 0 on the next cycle.
